// File: rtl/mssd_pkg.sv
// Shared MSSD framing types and widths, used by the transmitter and the receiver bench.
// Frame on the line: start(0), port, len, payload (N bits, MSB first), guard(1).
package mssd_pkg;

  localparam int PORT_W   = 2;
  localparam int LEN_W    = 4;
  localparam int DATA_MAX = 15;
  localparam int PORT_IW  = $clog2(PORT_W);
  localparam int LEN_IW   = $clog2(LEN_W);

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GUARD} state_t;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [LEN_W-1:0]  len;
  } hdr_t;

  // Left-justify the N valid payload bits so data[N-1] sits in the shifter MSB.
  function automatic logic [DATA_MAX-1:0] align_payload(input logic [DATA_MAX-1:0] d,
                                                        input logic [LEN_W-1:0]    n);
    return d << (LEN_W'(DATA_MAX) - n);
  endfunction

endpackage

// File: rtl/mssd_tx_if.sv
// Request and serial-line bundle of the MSSD transmitter.
// master = frame source / line observer, slave = transmitter.
interface mssd_tx_if;
  import mssd_pkg::*;

  logic                inValid;
  logic                inReady;
  logic [PORT_W-1:0]   port;
  logic [LEN_W-1:0]    len;
  logic [DATA_MAX-1:0] data;
  logic                serOut;
  logic                busy;
  logic                frameDone;

  modport master (output inValid, port, len, data,
                  input  inReady, serOut, busy, frameDone);

  modport slave  (input  inValid, port, len, data,
                  output inReady, serOut, busy, frameDone);

endinterface

// File: rtl/mssd_shift_reg.sv
// Loadable MSB-first shifter holding the payload; msb is the next bit to send.
// Latency: load/shift take effect at the edge; no backpressure (caller sequences it).
module mssd_shift_reg #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift_en,
  output logic         msb
);

  logic [W-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= load_dat;
    end else if (shift_en) begin
      sh_q <= {sh_q[W-2:0], 1'b0};
    end
  end

  assign msb = sh_q[W-1];

endmodule

// File: rtl/mssd_tx.sv
// MSSD serial frame transmitter: start bit one cycle after accept, frame is 8+N cycles.
// Backpressure: inReady only in IDLE/GUARD, so back-to-back frames are separated by the guard bit.
module mssd_tx
  import mssd_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mssd_tx_if.slave bus
);

  state_t              state_q, state_d;
  hdr_t                hdr_q;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                ser_q, ser_d;
  logic                accept;
  logic                shift_en;
  logic                sh_msb;
  logic [DATA_MAX-1:0] load_dat;

  assign bus.inReady   = (state_q == IDLE) || (state_q == GUARD);
  assign accept        = bus.inValid && bus.inReady;
  assign bus.serOut    = ser_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frameDone = (state_q == GUARD);

  assign load_dat = align_payload(bus.data, bus.len);
  assign shift_en = (state_d == DATA);

  mssd_shift_reg #(.W(DATA_MAX)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_dat (load_dat),
    .shift_en (shift_en),
    .msb      (sh_msb)
  );

  // ser_d is the bit for the state being entered, so serOut comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b1;
    case (state_q)
      IDLE, GUARD: begin
        if (accept) begin
          state_d = START;
          cnt_d   = '0;
          ser_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = PORT;
        cnt_d   = LEN_W'(PORT_W - 1);
        ser_d   = hdr_q.port[cnt_d[PORT_IW-1:0]];
      end
      PORT: begin
        if (cnt_q == '0) begin
          state_d = LEN;
          cnt_d   = LEN_W'(LEN_W - 1);
          ser_d   = hdr_q.len[cnt_d[LEN_IW-1:0]];
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          ser_d = hdr_q.port[cnt_d[PORT_IW-1:0]];
        end
      end
      LEN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
          ser_d = hdr_q.len[cnt_d[LEN_IW-1:0]];
        end else if (hdr_q.len != '0) begin
          state_d = DATA;
          cnt_d   = hdr_q.len - LEN_W'(1);
          ser_d   = sh_msb;
        end else begin
          state_d = GUARD;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          ser_d = sh_msb;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      if (accept) begin
        hdr_q.port <= bus.port;
        hdr_q.len  <= bus.len;
      end
    end
  end

endmodule

// File: tb/tb_mssd_tx.sv
// Bench for mssd_tx: per-cycle line expectations and a serial receiver model,
// both fed from scoreboard queues filled as requests are driven.
module tb_mssd_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mssd_tx_if bus();

  mssd_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {serOut, busy, frameDone, inReady}
  typedef logic [3:0] exp_t;
  localparam exp_t IDLE_E = 4'b1001;

  typedef struct packed {
    logic [1:0]  p;
    logic [3:0]  l;
    logic [14:0] d;
  } req_t;

  exp_t exp_q[$];
  req_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t obs();
    return {bus.serOut, bus.busy, bus.frameDone, bus.inReady};
  endfunction

  // Reference line model of one frame, one entry per cycle from the start bit.
  function automatic void push_frame(input logic [1:0] p, input logic [3:0] l,
                                     input logic [14:0] d);
    exp_q.push_back(4'b0100);
    for (int i = 1; i >= 0; i--) exp_q.push_back({p[i], 3'b100});
    for (int i = 3; i >= 0; i--) exp_q.push_back({l[i], 3'b100});
    for (int i = int'(l) - 1; i >= 0; i--) exp_q.push_back({d[i], 3'b100});
    exp_q.push_back(4'b1111);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.inValid = 1'b1;
    bus.port = 2'd3; bus.len = 4'd15; bus.data = 15'h7FFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = IDLE_E; n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL reset_hold got %b want %b", obs(), e);
    end
    rst = 1'b0; bus.inValid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL reset_release got %b want %b", obs(), e);
    end
  endtask

  task automatic test_spec_frame();
    logic [19:0] lit;
    exp_t e;
    lit = 20'h79579;
    @(negedge clk);
    bus.port = 2'd3; bus.len = 4'd12; bus.data = 15'h0ABC; bus.inValid = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back({lit[19-i], 1'b1, i == 19, i == 19});
    exp_q.push_back(IDLE_E);
    @(posedge clk); #1 bus.inValid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL spec_frame cyc %0d got %b want %b", c, obs(), e);
      end
      bus.port = 2'($urandom); bus.len = 4'($urandom); bus.data = 15'($urandom);
    end
  endtask

  task automatic test_len0();
    exp_t e;
    int   busy_cnt = 0;
    @(negedge clk);
    bus.port = 2'd1; bus.len = 4'd0; bus.data = 15'h7FFF; bus.inValid = 1'b1;
    push_frame(2'd1, 4'd0, 15'h7FFF);
    exp_q.push_back(IDLE_E);
    @(posedge clk); #1 bus.inValid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL len0 cyc %0d got %b want %b", c, obs(), e);
      end
    end
    n_cmp++;
    if (busy_cnt != 8) begin
      n_bad++; $display("FAIL len0_busy_cycles got %0d want 8", busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   sent2 = 1'b0;
    @(negedge clk);
    bus.port = 2'd2; bus.len = 4'd3; bus.data = 15'h0005; bus.inValid = 1'b1;
    push_frame(2'd2, 4'd3, 15'h0005);
    push_frame(2'd0, 4'd15, 15'h7FFF);
    exp_q.push_back(IDLE_E);
    @(posedge clk); #1;
    bus.port = 2'd0; bus.len = 4'd15; bus.data = 15'h7FFF;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL back_to_back cyc %0d got %b want %b", c, obs(), e);
      end
      if (!sent2 && bus.inReady === 1'b1) begin
        sent2 = 1'b1;
        @(posedge clk); #1 bus.inValid = 1'b0;
      end
    end
    bus.inValid = 1'b0;
  endtask

  task automatic test_rst_midframe();
    exp_t e;
    @(negedge clk);
    bus.port = 2'd2; bus.len = 4'd9; bus.data = 15'h1B5; bus.inValid = 1'b1;
    push_frame(2'd2, 4'd9, 15'h1B5);
    @(posedge clk); #1 bus.inValid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL rst_mid_pre cyc %0d got %b want %b", c, obs(), e);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    for (int c = 8; c <= 20; c++) begin
      @(negedge clk);
      e = IDLE_E; n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL rst_mid_post cyc %0d got %b want %b", c, obs(), e);
      end
    end
  endtask

  task automatic test_rst_accept();
    exp_t e;
    @(negedge clk);
    bus.port = 2'd1; bus.len = 4'd5; bus.data = 15'h001F; bus.inValid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.inValid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      e = IDLE_E; n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL rst_vs_accept cyc %0d got %b want %b", c, obs(), e);
      end
    end
  endtask

  task automatic test_loopback();
    req_t        r, x;
    logic [1:0]  rp;
    logic [3:0]  rl;
    logic [14:0] rd, want_d;
    logic [15:0] mask;
    logic        err;
    int          gap;
    @(negedge clk);
    for (int f = 0; f < 50; f++) begin
      r.p = 2'($urandom); r.l = 4'($urandom); r.d = 15'($urandom);
      gap = int'($urandom_range(2, 0));
      n_cmp++;
      if (bus.inReady !== 1'b1) begin
        n_bad++; $display("FAIL lb_ready frame %0d got %b want 1", f, bus.inReady);
      end
      bus.port = r.p; bus.len = r.l; bus.data = r.d; bus.inValid = 1'b1;
      sb_q.push_back(r);
      @(posedge clk); #1 bus.inValid = 1'b0;
      rp = '0; rl = '0; rd = '0;
      @(negedge clk);
      err = (bus.serOut !== 1'b0);
      for (int i = 0; i < 2; i++) begin @(negedge clk); rp = {rp[0], bus.serOut}; end
      for (int i = 0; i < 4; i++) begin @(negedge clk); rl = {rl[2:0], bus.serOut}; end
      for (int i = 0; i < int'(rl); i++) begin @(negedge clk); rd = {rd[13:0], bus.serOut}; end
      @(negedge clk);
      err = err || (bus.serOut !== 1'b1) || (bus.frameDone !== 1'b1);
      x = sb_q.pop_front();
      mask = (16'd1 << x.l) - 16'd1;
      want_d = x.d & mask[14:0];
      n_cmp++;
      if (err) begin
        n_bad++; $display("FAIL lb_error frame %0d got 1 want 0", f);
      end
      n_cmp++;
      if ({rp, rl, rd} !== {x.p, x.l, want_d}) begin
        n_bad++;
        $display("FAIL lb_frame %0d got port=%0d len=%0d data=%h want port=%0d len=%0d data=%h",
                 f, rp, rl, rd, x.p, x.l, want_d);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_cmp++;
        if (obs() !== IDLE_E) begin
          n_bad++; $display("FAIL lb_gap frame %0d got %b want %b", f, obs(), IDLE_E);
        end
      end
    end
  endtask

  initial begin
    bus.inValid = 1'b0; bus.port = '0; bus.len = '0; bus.data = '0;
    test_reset();
    test_spec_frame();
    test_len0();
    test_back_to_back();
    test_rst_midframe();
    test_rst_accept();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mssd_tx.md
MSSD_TX -- requirements
Module: mssd_tx

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 inValid  input  1  frame request valid.
REQ-004 inReady  output  1  block can accept a frame this cycle.
REQ-005 port  input  2  destination port number, sampled on accept.
REQ-006 len  input  4  number of payload bits N (0..15), sampled on accept.
REQ-007 data  input  15  payload; bit data[N-1] is sent first, down to data[0]; bits above N-1 are ignored; sampled on accept.
REQ-008 serOut  output  1  serial line; idle level 1.
REQ-009 busy  output  1  frame in progress, from start bit through guard bit.
REQ-010 frameDone  output  1  one-cycle pulse during the guard bit of each frame.

Function
REQ-011 Frame on serOut SHALL be, one bit per clk: start bit 0; port MSB-first (2 bits); len MSB-first (4 bits); N payload bits; one guard bit 1. Total is 8+N cycles.
REQ-012 An accept SHALL occur on a rising edge where inValid && inReady; port, len and data SHALL be captured into internal registers at that edge.
REQ-013 The start bit SHALL appear on serOut in the cycle immediately after the accept edge (latency 1).
REQ-014 The FSM SHALL have the states IDLE, START, PORT, LEN, DATA and GUARD.
REQ-015 FSM transitions: IDLE->START on accept; START->PORT after 1 cycle; PORT->LEN after 2; LEN->DATA after 4 when N>0, else LEN->GUARD; DATA->GUARD after N; GUARD->START on accept, else GUARD->IDLE.
REQ-016 inReady SHALL be 1 in IDLE and GUARD and 0 in all other states, so back-to-back frames are separated by exactly one idle bit.
REQ-017 serOut SHALL be 1 in IDLE and GUARD, and SHALL be registered (no combinational path from inputs).
REQ-018 busy SHALL be 1 in START, PORT, LEN, DATA and GUARD, and 0 in IDLE.
REQ-019 frameDone SHALL be 1 exactly in the GUARD cycle.
REQ-020 N=0 SHALL produce a valid 8-cycle frame with no payload bits.
REQ-021 N=15 SHALL send all of data[14:0].
REQ-022 A single bit counter (4 bits) SHALL count the bits within each field and reload at each field boundary; it SHALL NOT wrap inside a field.
REQ-023 Input changes while busy, other than during GUARD, SHALL NOT affect the frame in flight.

Reset
REQ-024 rst=1 at a rising edge SHALL force: state IDLE, serOut=1, inReady=1, busy=0, frameDone=0, capture registers and counter cleared.
REQ-025 rst mid-frame SHALL abort the frame; serOut SHALL be 1 from the next cycle, with no partial guard and no frameDone pulse.
REQ-026 rst has priority over a simultaneous accept; no frame is started.

Structure
REQ-027 Package mssd_pkg SHALL hold the state enum and the constants PORT_W=2, LEN_W=4 and DATA_MAX=15, shared with the MSSD receiver bench.
REQ-028 One sub-module, mssd_shift_reg, SHALL be used: a loadable MSB-first 15-bit shifter with a parallel load and a shift enable. The rest stays in the FSM.

Verification
REQ-029 Reset, then port=3, len=12, data=0x0ABC with a single-cycle inValid -> serOut sequence 0,1,1,1,1,0,0, then 101010111100, then 1; frameDone pulses at cycle 20 after the accept.
REQ-030 port=1, len=0 -> serOut 0,0,1,0,0,0,0,1; busy high for exactly 8 cycles.
REQ-031 inValid held high with two requests (port=2, len=3, data=0x5; then port=0, len=15, data=0x7FFF) -> the second start bit follows the first frame's guard cycle with no extra idle; the second payload is fifteen 1s.
REQ-032 rst asserted at the 4th LEN bit of a frame -> serOut=1, busy=0 and inReady=1 from the next cycle; no frameDone.
REQ-033 Loopback into the MSSD receiver with 50 random frames (random port, len, data) -> the receiver's activePort and reassembled payload match the stimulus, and its error output is never set.
